// File: rtl/fm_stream_tx.sv
// Feature-map stream transmitter: captures a flat FP16 frame and sends it one word per beat with channel/pixel tags.
// Optional macro FM_TX_RELU_EN clamps negative words (sign bit set) to zero on the output path.
module fm_stream_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int K          = 1,
  parameter int H          = 1,
  parameter int W          = 1,
  localparam int N         = K * H * W,
  localparam int HW        = H * W,
  localparam int CW        = (K > 1) ? $clog2(K) : 1,
  localparam int PW        = (HW > 1) ? $clog2(HW) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N*DATA_WIDTH-1:0]   in_vec,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [CW-1:0]             out_ch,
  output logic [PW-1:0]             out_pix,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int CNTW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [CNTW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]           ch_q, ch_d;
  logic [PW-1:0]           pix_q, pix_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   buf_q [N];
  logic [DATA_WIDTH-1:0]   buf_d [N];
  logic [DATA_WIDTH-1:0]   word;
  logic                    is_last;

  function automatic logic [DATA_WIDTH-1:0] tx_word(input logic [DATA_WIDTH-1:0] w);
`ifdef FM_TX_RELU_EN
    return w[DATA_WIDTH-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  assign is_last = (cnt_q == CNTW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    done_d  = 1'b0;
    buf_d   = buf_q;
    word    = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CNTW'(i)) word = buf_q[i];
    end
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < N; i++) buf_d[i] = in_vec[i*DATA_WIDTH +: DATA_WIDTH];
          cnt_d   = '0;
          ch_d    = '0;
          pix_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (is_last) begin
            // Counters return to zero so idle tags read 0.
            state_d = IDLE;
            cnt_d   = '0;
            ch_d    = '0;
            pix_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
            if (pix_q == PW'(HW - 1)) begin
              pix_d = '0;
              ch_d  = ch_q + CW'(1);
            end else begin
              pix_d = pix_q + PW'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      pix_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      done_q  <= done_d;
    end
  end

  // Frame buffer carries no reset; its contents are only visible while in SEND.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign in_ready   = (state_q == IDLE) && !reset;
  assign out_valid  = (state_q == SEND);
  assign out_last   = (state_q == SEND) && is_last;
  assign out_data   = (state_q == SEND) ? tx_word(word) : '0;
  assign out_ch     = ch_q;
  assign out_pix    = pix_q;
  assign busy       = (state_q == SEND);
  assign frame_done = done_q;

endmodule
